// File: rtl/multiplier.sv
// Four-stage pipelined RV32M multiply unit (MUL, MULH, MULHSU, MULHU).
// The 33x33 signed product is built from four half-width partial products.
module multiplier #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid_input,
  input  logic [1:0]           i_op,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_valid_output,
  output logic [WIDTH-1:0]     o_result,
  output logic [2*WIDTH-1:0]   o_product,
  output logic [TAG_WIDTH-1:0] o_tag
);

  localparam int HALF = WIDTH / 2;
  localparam int PPW  = WIDTH + 2;  // width of a (HALF+1)x(HALF+1) signed product

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic [WIDTH:0]          a_ext_s, b_ext_s;
  logic [WIDTH:0]          a_r, b_r;
  logic [PPW-1:0]          a_lo_s, a_hi_s, b_lo_s, b_hi_s;
  logic [WIDTH-1:0]        ll_r;
  logic [PPW-1:0]          lh_r, hl_r, hh_r;
  logic [2*WIDTH-1:0]      lh_ext_s, hl_ext_s, hh_ext_s, product_s;
  logic [2*WIDTH-1:0]      product_r;
  logic                    v0_r, v1_r, v2_r;
  logic [1:0]              op0_r, op1_r, op2_r;
  logic [TAG_WIDTH-1:0]    tag0_r, tag1_r, tag2_r;

  // Operand extension: rs1 is signed unless MULHU, rs2 signed only for MUL/MULH.
  always_comb begin
    a_ext_s = {1'b0, i_multiplicand};
    b_ext_s = {1'b0, i_multiplier};
    if (i_op != OP_MULHU) begin
      a_ext_s = {i_multiplicand[WIDTH-1], i_multiplicand};
    end else begin
      a_ext_s = {1'b0, i_multiplicand};
    end
    if (i_op[1] == 1'b0) begin
      b_ext_s = {i_multiplier[WIDTH-1], i_multiplier};
    end else begin
      b_ext_s = {1'b0, i_multiplier};
    end
  end

  // Operand split, sign-extended to PPW so plain modular multiplies are exact.
  always_comb begin
    a_lo_s = {{(PPW-HALF){1'b0}}, a_r[HALF-1:0]};
    b_lo_s = {{(PPW-HALF){1'b0}}, b_r[HALF-1:0]};
    a_hi_s = {{(PPW-HALF-1){a_r[WIDTH]}}, a_r[WIDTH:HALF]};
    b_hi_s = {{(PPW-HALF-1){b_r[WIDTH]}}, b_r[WIDTH:HALF]};
  end

  // Partial-product recombination, wrapping to 2*WIDTH bits.
  always_comb begin
    lh_ext_s  = {{(2*WIDTH-PPW){lh_r[PPW-1]}}, lh_r};
    hl_ext_s  = {{(2*WIDTH-PPW){hl_r[PPW-1]}}, hl_r};
    hh_ext_s  = {{(2*WIDTH-PPW){hh_r[PPW-1]}}, hh_r};
    product_s = (hh_ext_s << WIDTH) + ((lh_ext_s + hl_ext_s) << HALF)
              + {{WIDTH{1'b0}}, ll_r};
  end

  // Data path stages; contents are don't-care while the matching valid is low.
  always_ff @(posedge i_clk) begin
    a_r       <= a_ext_s;
    b_r       <= b_ext_s;
    ll_r      <= a_lo_s[WIDTH-1:0] * b_lo_s[WIDTH-1:0];
    lh_r      <= a_lo_s * b_hi_s;
    hl_r      <= a_hi_s * b_lo_s;
    hh_r      <= a_hi_s * b_hi_s;
    product_r <= product_s;
    op0_r     <= i_op;
    op1_r     <= op0_r;
    op2_r     <= op1_r;
    tag0_r    <= i_tag;
    tag1_r    <= tag0_r;
    tag2_r    <= tag1_r;
  end

  // Valid shift pipeline and registered outputs; reset drops all in-flight ops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v0_r           <= 1'b0;
      v1_r           <= 1'b0;
      v2_r           <= 1'b0;
      o_valid_output <= 1'b0;
      o_result       <= {WIDTH{1'b0}};
      o_product      <= {(2*WIDTH){1'b0}};
      o_tag          <= {TAG_WIDTH{1'b0}};
    end else begin
      v0_r           <= i_valid_input;
      v1_r           <= v0_r;
      v2_r           <= v1_r;
      o_valid_output <= v2_r;
      o_product      <= product_r;
      o_tag          <= tag2_r;
      if (op2_r == OP_MUL) begin
        o_result <= product_r[WIDTH-1:0];
      end else begin
        o_result <= product_r[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the pipelined RV32M multiplier.
module tb_multiplier;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid_input;
  logic [1:0]  i_op;
  logic [31:0] i_multiplicand;
  logic [31:0] i_multiplier;
  logic [4:0]  i_tag;
  logic        o_valid_output;
  logic [31:0] o_result;
  logic [63:0] o_product;
  logic [4:0]  o_tag;

  int n_vec = 0;
  int n_err = 0;

  multiplier #(.WIDTH(32), .TAG_WIDTH(5)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid_input  (i_valid_input),
    .i_op           (i_op),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_tag          (i_tag),
    .o_valid_output (o_valid_output),
    .o_result       (o_result),
    .o_product      (o_product),
    .o_tag          (o_tag)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    i_valid_input  = v;
    i_op           = op;
    i_multiplicand = a;
    i_multiplier   = b;
    i_tag          = t;
  endtask

  // 64-bit reference: extend per op, multiply modulo 2^64.
  function automatic logic [63:0] gold(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (op != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0000_0000, a};
    eb = (op[1] == 1'b0 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0000_0000, b};
    return ea * eb;
  endfunction

  // Launch one op, idle, and check the result exactly four edges later.
  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t,
                         input logic [31:0] exp_res, input logic [63:0] exp_prod);
    drive(1'b1, op, a, b, t);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 1; i < 4; i++) begin
      check({name, "_early_valid"}, {63'd0, o_valid_output}, 64'd0);
      tick();
    end
    check({name, "_valid"}, {63'd0, o_valid_output}, 64'd1);
    check({name, "_result"}, {32'd0, o_result}, {32'd0, exp_res});
    check({name, "_product"}, o_product, exp_prod);
    check({name, "_tag"}, {59'd0, o_tag}, {59'd0, t});
    tick();
    check({name, "_valid_drop"}, {63'd0, o_valid_output}, 64'd0);
  endtask

  logic [1:0]  s_op [8];
  logic [31:0] s_a  [8];
  logic [31:0] s_b  [8];

  initial begin
    logic [63:0] ep;
    logic [31:0] er;
    int j;

    i_rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    check("rst_valid", {63'd0, o_valid_output}, 64'd0);
    check("rst_result", {32'd0, o_result}, 64'd0);
    check("rst_product", o_product, 64'd0);
    check("rst_tag", {59'd0, o_tag}, 64'd0);
    i_rst = 1'b0;
    tick();

    run_one("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd1, 32'h0000_002A, 64'h0000_0000_0000_002A);
    run_one("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2,
            32'h4000_0000, 64'h4000_0000_0000_0000);
    run_one("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
            32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    run_one("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,
            32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001);
    run_one("mul_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,
            32'h0000_0001, 64'h0000_0000_0000_0001);
    run_one("mul_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,
            32'h8000_0000, 64'h0000_0000_8000_0000);

    s_op[0] = 2'b00; s_a[0] = 32'h8000_0000; s_b[0] = 32'hFFFF_FFFF;
    s_op[1] = 2'b01; s_a[1] = 32'h1234_5678; s_b[1] = 32'h9ABC_DEF0;
    s_op[2] = 2'b10; s_a[2] = 32'h8000_0000; s_b[2] = 32'h0000_0003;
    s_op[3] = 2'b11; s_a[3] = 32'hDEAD_BEEF; s_b[3] = 32'h0001_0000;
    s_op[4] = 2'b00; s_a[4] = 32'hFFFF_FFFE; s_b[4] = 32'h0000_0005;
    s_op[5] = 2'b01; s_a[5] = 32'h7FFF_FFFF; s_b[5] = 32'h7FFF_FFFF;
    s_op[6] = 2'b10; s_a[6] = 32'h0000_0005; s_b[6] = 32'hFFFF_FFFF;
    s_op[7] = 2'b11; s_a[7] = 32'h0000_0000; s_b[7] = 32'h1234_5678;

    // Back-to-back stream: op k is visible four negedges after it is driven.
    for (int k = 0; k < 13; k++) begin
      if (k >= 4) begin
        j = k - 4;
        if (j < 8) begin
          ep = gold(s_op[j], s_a[j], s_b[j]);
          er = (s_op[j] == 2'b00) ? ep[31:0] : ep[63:32];
          check("stream_valid", {63'd0, o_valid_output}, 64'd1);
          check("stream_tag", {59'd0, o_tag}, j[63:0]);
          check("stream_result", {32'd0, o_result}, {32'd0, er});
          check("stream_product", o_product, ep);
        end else begin
          check("stream_end_valid", {63'd0, o_valid_output}, 64'd0);
        end
      end
      if (k < 8) begin
        drive(1'b1, s_op[k], s_a[k], s_b[k], k[4:0]);
      end else begin
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      end
      tick();
    end

    // Reset with three ops in flight plus one launched during the reset cycle.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b00, 32'd100 + k, 32'd3, 5'd10 + k[4:0]);
      tick();
    end
    i_rst = 1'b1;
    drive(1'b1, 2'b11, 32'd9, 32'd9, 5'd20);
    tick();
    i_rst = 1'b0;
    check("postrst_result", {32'd0, o_result}, 64'd0);
    check("postrst_product", o_product, 64'd0);
    check("postrst_tag", {59'd0, o_tag}, 64'd0);
    drive(1'b1, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd21);
    for (int k = 0; k < 4; k++) begin
      check("postrst_no_valid", {63'd0, o_valid_output}, 64'd0);
      tick();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    end
    check("postrst_op_valid", {63'd0, o_valid_output}, 64'd1);
    check("postrst_op_result", {32'd0, o_result}, 64'h0000_0000_FFFF_FFFF);
    check("postrst_op_product", o_product, 64'hFFFF_FFFF_FFFF_FFFA);
    check("postrst_op_tag", {59'd0, o_tag}, 64'd21);
    tick();
    check("postrst_drop", {63'd0, o_valid_output}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
